// File: rtl/wb_pkg.sv
// Shared opcode constants, writeback source selector and commit-queue entry
// layout for the writeback commit queue.
package wb_pkg;

  // Widest data path the entry layout carries; narrower XLEN zero-extends.
  localparam int WB_MAX_XLEN = 64;

  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_OP_32  = 7'b0111011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  typedef enum logic [1:0] {
    WB_NONE,
    WB_ALU,
    WB_LOAD,
    WB_LINK
  } wb_src_e;

  typedef struct packed {
    logic [4:0]             dest;
    logic [WB_MAX_XLEN-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_src_decode.sv
// Per-channel writeback decode: picks the result source from the opcode and
// flags whether the request actually writes the register file.
module wb_src_decode
  import wb_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [4:0] dest,
  output wb_src_e    src,
  output logic       write
);

  always_comb begin
    src = WB_NONE;
    case (opcode)
      OP_OP, OP_OP_32, OP_IMM, OP_IMM_32, OP_AUIPC, OP_LUI: src = WB_ALU;
      OP_LOAD:                                              src = WB_LOAD;
      OP_JAL, OP_JALR:                                      src = WB_LINK;
      default:                                              src = WB_NONE;
    endcase
    write = (src != WB_NONE) && (dest != '0);
  end

endmodule

// File: rtl/wb_commit_queue.sv
// Multi-channel writeback commit queue: accepts up to NCH requests per cycle,
// drains them in order to a single register-file write port, and forwards.
module wb_commit_queue
  import wb_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int NCH   = 2,
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flush,
  input  logic [NCH-1:0]            ch_valid,
  output logic [NCH-1:0]            ch_ready,
  input  logic [NCH-1:0][6:0]       ch_opcode,
  input  logic [NCH-1:0][4:0]       ch_dest,
  input  logic [NCH-1:0][XLEN-1:0]  ch_alu,
  input  logic [NCH-1:0][XLEN-1:0]  ch_load,
  input  logic [NCH-1:0][XLEN-1:0]  ch_pc,
  output logic                      rf_we,
  output logic [4:0]                rf_waddr,
  output logic [XLEN-1:0]           rf_wdata,
  input  logic                      rf_ack,
  input  logic [4:0]                fwd_addr,
  output logic                      fwd_hit,
  output logic [XLEN-1:0]           fwd_data,
  output logic [$clog2(NCH+2)-1:0]  retire_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam int RW = $clog2(NCH+2);

  wb_entry_t                 mem [DEPTH];
  logic [PW-1:0]             rd_ptr;
  logic [PW-1:0]             wr_ptr;
  logic [CW-1:0]             count;
  logic [CW-1:0]             free_cnt;

  wb_src_e                   src [NCH];
  logic [NCH-1:0]            wr_flag;
  logic [NCH-1:0]            accept;
  logic [NCH-1:0]            push_en;
  logic [NCH-1:0][XLEN-1:0]  ch_data;
  logic [NCH-1:0][PW-1:0]    slot;
  logic [CW-1:0]             push_cnt;
  logic [RW-1:0]             nonwr_cnt;
  logic                      pop;
  logic [PW-1:0]             fwd_idx;

  for (genvar g = 0; g < NCH; g++) begin : g_dec
    wb_src_decode u_dec (
      .opcode (ch_opcode[g]),
      .dest   (ch_dest[g]),
      .src    (src[g]),
      .write  (wr_flag[g])
    );
  end

  // Credit comes only from the occupancy at cycle start; a same-cycle pop
  // never frees a slot for this cycle's requests.
  assign free_cnt = CW'(DEPTH) - count;

  always_comb begin
    ch_ready = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      ch_ready[i] = !reset && !flush && (free_cnt > CW'(i));
    end
  end

  assign accept = ch_valid & ch_ready;

  always_comb begin
    ch_data = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      case (src[i])
        WB_ALU:  ch_data[i] = ch_alu[i];
        WB_LOAD: ch_data[i] = ch_load[i];
        WB_LINK: ch_data[i] = ch_pc[i] + XLEN'(4);
        default: ch_data[i] = '0;
      endcase
    end
  end

  // Lower channels take earlier slots so they end up older in the queue.
  always_comb begin
    push_cnt  = '0;
    nonwr_cnt = '0;
    push_en   = '0;
    slot      = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      slot[i] = wr_ptr + PW'(push_cnt);
      if (accept[i]) begin
        if (wr_flag[i]) begin
          push_en[i] = 1'b1;
          push_cnt   = push_cnt + CW'(1);
        end else begin
          nonwr_cnt  = nonwr_cnt + RW'(1);
        end
      end
    end
  end

  assign rf_we    = (count != '0);
  assign pop      = rf_we && rf_ack;
  assign rf_waddr = rf_we ? mem[rd_ptr].dest : '0;
  assign rf_wdata = rf_we ? mem[rd_ptr].data[XLEN-1:0] : '0;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      retire_cnt <= '0;
    end else begin
      rd_ptr     <= rd_ptr + PW'(pop);
      wr_ptr     <= wr_ptr + PW'(push_cnt);
      count      <= count + push_cnt - CW'(pop);
      retire_cnt <= nonwr_cnt + RW'(pop);
    end
  end

  // push_en is already zero under reset/flush because ch_ready is low.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NCH; i++) begin
      if (push_en[i]) begin
        mem[slot[i]] <= '{dest: ch_dest[i], data: WB_MAX_XLEN'(ch_data[i])};
      end
    end
  end

  // Walk oldest to youngest so the last match seen is the youngest.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    fwd_idx  = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      fwd_idx = rd_ptr + PW'(k);
      if ((CW'(k) < count) && (fwd_addr != '0) && (mem[fwd_idx].dest == fwd_addr)) begin
        fwd_hit  = 1'b1;
        fwd_data = mem[fwd_idx].data[XLEN-1:0];
      end
    end
  end

endmodule
